// File: rtl/beep_sequencer.sv
// Melody sequencer: fetches note/duration words from a synchronous song ROM and drives a buzzer PWM.
// Define BEEP_GAP_EN to insert GAP_CYCLES of silence between consecutive notes.
`timescale 1ns/1ps
module beep_sequencer #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TICK_CYCLES = 6_250_000,
    parameter int unsigned NOTE_NUM    = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DUTY_SHIFT  = 1,
    parameter int unsigned GAP_CYCLES  = 500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              cnt_en,
    output logic [31:0]       counter_arr,
    output logic [31:0]       counter_ccr,
    output logic              busy,
    output logic              done
);

`ifdef BEEP_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    function automatic int unsigned note_hz(input int unsigned code);
        case (code)
            1:       return 131;
            2:       return 147;
            3:       return 165;
            4:       return 175;
            5:       return 196;
            6:       return 220;
            7:       return 247;
            8:       return 262;
            9:       return 294;
            10:      return 330;
            11:      return 349;
            12:      return 392;
            13:      return 440;
            14:      return 494;
            15:      return 524;
            16:      return 588;
            17:      return 660;
            18:      return 698;
            19:      return 784;
            20:      return 880;
            21:      return 988;
            default: return 0;
        endcase
    endfunction

    // Period table built at elaboration; CLK_HZ/f is rounded to the nearest clock before the -1.
    logic [31:0] w_period [0:31];
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_period
            localparam longint unsigned F   = 64'(note_hz(gi));
            localparam longint unsigned DIV = (F == 0) ? 64'd1 : F;
            localparam longint unsigned ARR = (F == 0) ? 64'd0 : (64'(CLK_HZ) + DIV / 2) / DIV - 1;
            assign w_period[gi] = ARR[31:0];
        end
    endgenerate

    state_t            r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_cnt_en;
    logic [31:0]       r_arr;
    logic [31:0]       r_ccr;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_tick_cnt;
    logic [2:0]        r_dur_cnt;
    logic [2:0]        r_dur;
    logic [31:0]       r_gap_cnt;

    logic [4:0] w_note;
    logic [2:0] w_dur;
    logic       w_is_tone;
    logic       w_is_end;
    logic       w_tick_last;
    logic       w_note_last;
    logic       w_addr_last;

    assign w_note      = rom_data[4:0];
    assign w_dur       = rom_data[7:5];
    assign w_is_tone   = (w_note != 5'd0) && (w_note <= 5'd21);
    assign w_is_end    = (w_note == 5'd31);
    assign w_tick_last = (r_tick_cnt == 32'(TICK_CYCLES - 1));
    assign w_note_last = w_tick_last && (r_dur_cnt == r_dur);
    assign w_addr_last = (r_rom_addr == ADDR_W'(NOTE_NUM - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rom_addr <= '0;
            r_cnt_en   <= 1'b0;
            r_arr      <= '0;
            r_ccr      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tick_cnt <= '0;
            r_dur_cnt  <= '0;
            r_dur      <= '0;
            r_gap_cnt  <= '0;
        end else if (stop) begin
            r_state    <= S_IDLE;
            r_rom_addr <= '0;
            r_cnt_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_rom_addr <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    if (w_is_end) begin
                        if (loop_en) begin
                            r_rom_addr <= '0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        // Rests keep the previous period so the PWM simply idles with cnt_en low.
                        if (w_is_tone) begin
                            r_arr <= w_period[w_note];
                            r_ccr <= w_period[w_note] >> DUTY_SHIFT;
                        end
                        r_cnt_en   <= w_is_tone;
                        r_dur      <= w_dur;
                        r_tick_cnt <= '0;
                        r_dur_cnt  <= '0;
                        r_state    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (w_note_last) begin
                        r_cnt_en <= 1'b0;
                        if (w_addr_last) begin
                            if (loop_en) begin
                                r_rom_addr <= '0;
                                r_state    <= S_FETCH;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else if (GAP_EN) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end else begin
                            r_rom_addr <= r_rom_addr + ADDR_W'(1);
                            r_state    <= S_FETCH;
                        end
                    end else if (w_tick_last) begin
                        r_tick_cnt <= '0;
                        r_dur_cnt  <= r_dur_cnt + 3'd1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == 32'(GAP_CYCLES - 1)) begin
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        r_state    <= S_FETCH;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_cnt_en <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr    = r_rom_addr;
    assign cnt_en      = r_cnt_en;
    assign counter_arr = r_arr;
    assign counter_ccr = r_ccr;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer: table of one-note songs plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_beep_sequencer;
    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned TICK_CYCLES = 10;
    localparam int unsigned NOTE_NUM    = 8;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned GAP_CYCLES  = 3;
`ifdef BEEP_GAP_EN
    localparam int GAP_EXTRA = 3;
`else
    localparam int GAP_EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_q;
    logic              cnt_en;
    logic [31:0]       counter_arr;
    logic [31:0]       counter_ccr;
    logic              busy;
    logic              done;

    beep_sequencer #(
        .CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK_CYCLES), .NOTE_NUM(NOTE_NUM),
        .ADDR_W(ADDR_W), .DUTY_SHIFT(1), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_data(rom_q), .cnt_en(cnt_en),
        .counter_arr(counter_arr), .counter_ccr(counter_ccr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [0:NOTE_NUM-1];
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    typedef struct {
        logic [7:0]  word;
        int          exp_en;
        logic [31:0] exp_arr;
        logic [31:0] exp_ccr;
        int          exp_max_addr;
    } vec_t;
    vec_t vecs [12];

    int n_vec = 0;
    int n_err = 0;

    int          m_en_cnt, m_done_cnt, m_max_addr, m_done_idx, m_exit_idx;
    logic [31:0] m_arr, m_ccr;
    bit          m_timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_song(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        for (int k = 0; k < NOTE_NUM; k++) rom_mem[k] = 8'h1F;
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
    endtask

    function automatic int exp_done_idx(input logic [7:0] w);
        if (w[4:0] == 5'd31) return 2;
        return 4 + (int'(w[7:5]) + 1) * int'(TICK_CYCLES) + GAP_EXTRA;
    endfunction

    // Pulses start, then samples once per clock until busy falls; restart_at re-pulses start mid-song.
    task automatic run_song(input int budget, input int restart_at);
        m_en_cnt = 0; m_done_cnt = 0; m_max_addr = 0; m_done_idx = -1; m_exit_idx = -1;
        m_arr = '0; m_ccr = '0; m_timeout = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (cnt_en) m_en_cnt++;
            if (done) begin
                m_done_cnt++;
                if (m_done_idx < 0) m_done_idx = c;
                m_arr = counter_arr;
                m_ccr = counter_ccr;
            end
            if (int'(rom_addr) > m_max_addr) m_max_addr = int'(rom_addr);
            if (!busy) begin
                m_timeout = 1'b0;
                m_exit_idx = c;
                break;
            end
            start = (c == restart_at);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic wait_en(input logic val, input int budget, output int n);
        n = -1;
        for (int c = 0; c < budget; c++) begin
            if (cnt_en == val) begin
                n = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wraps, en_cnt, done_cnt, busy_cnt;
        logic [ADDR_W-1:0] prev_addr;

        vecs[0]  = '{8'h0D, 10, 32'd113635, 32'd56817,  1};
        vecs[1]  = '{8'h48, 30, 32'd190839, 32'd95419,  1};
        vecs[2]  = '{8'h20,  0, 32'd190839, 32'd95419,  1};
        vecs[3]  = '{8'h01, 10, 32'd381678, 32'd190839, 1};
        vecs[4]  = '{8'h07, 10, 32'd202428, 32'd101214, 1};
        vecs[5]  = '{8'hF2, 80, 32'd71632,  32'd35816,  1};
        vecs[6]  = '{8'h15, 10, 32'd50606,  32'd25303,  1};
        vecs[7]  = '{8'h16,  0, 32'd50606,  32'd25303,  1};
        vecs[8]  = '{8'h1E,  0, 32'd50606,  32'd25303,  1};
        vecs[9]  = '{8'h14, 10, 32'd56817,  32'd28408,  1};
        vecs[10] = '{8'h0E, 10, 32'd101214, 32'd50607,  1};
        vecs[11] = '{8'h1F,  0, 32'd101214, 32'd50607,  0};

        load_song(8'h1F, 8'h1F, 8'h1F);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_rom_addr", rom_addr, 0);
        check("reset_cnt_en", cnt_en, 0);
        check("reset_arr", counter_arr, 0);
        check("reset_ccr", counter_ccr, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        $display("reset: rom_addr=%0d cnt_en=%0d busy=%0d done=%0d", rom_addr, cnt_en, busy, done);

        for (int i = 0; i < 12; i++) begin
            load_song(vecs[i].word, 8'h1F, 8'h1F);
            run_song(300, -1);
            check($sformatf("v%0d_timeout", i), m_timeout, 0);
            check($sformatf("v%0d_en_cycles", i), m_en_cnt, vecs[i].exp_en);
            check($sformatf("v%0d_arr", i), m_arr, vecs[i].exp_arr);
            check($sformatf("v%0d_ccr", i), m_ccr, vecs[i].exp_ccr);
            check($sformatf("v%0d_done_pulses", i), m_done_cnt, 1);
            check($sformatf("v%0d_done_cycle", i), m_done_idx, exp_done_idx(vecs[i].word));
            check($sformatf("v%0d_idle_after_done", i), m_exit_idx, exp_done_idx(vecs[i].word) + 1);
            check($sformatf("v%0d_max_addr", i), m_max_addr, vecs[i].exp_max_addr);
            $display("vec %0d word=%h en=%0d arr=%0d ccr=%0d done_at=%0d",
                     i, vecs[i].word, m_en_cnt, m_arr, m_ccr, m_done_idx);
        end

        // Full-length song with no marker: ends at the last ROM address.
        for (int k = 0; k < NOTE_NUM; k++) rom_mem[k] = 8'(k + 1);
        run_song(400, -1);
        check("full_timeout", m_timeout, 0);
        check("full_en_cycles", m_en_cnt, 80);
        check("full_max_addr", m_max_addr, NOTE_NUM - 1);
        check("full_done_pulses", m_done_cnt, 1);
        check("full_done_cycle", m_done_idx, 96 + 7 * GAP_EXTRA);
        check("full_last_arr", m_arr, 190839);
        $display("full song: en=%0d max_addr=%0d done_at=%0d", m_en_cnt, m_max_addr, m_done_idx);

        // start while busy is ignored.
        load_song(8'h48, 8'h1F, 8'h1F);
        run_song(300, 10);
        check("restart_ign_en", m_en_cnt, 30);
        check("restart_ign_done_cycle", m_done_idx, 34 + GAP_EXTRA);
        $display("start-while-busy: en=%0d done_at=%0d", m_en_cnt, m_done_idx);

        // Silence between two notes.
        load_song(8'h0D, 8'h0D, 8'h1F);
        start = 1'b1; tick(); start = 1'b0;
        wait_en(1'b1, 50, n);
        check("gap_first_rise", n, 2);
        wait_en(1'b0, 50, n);
        check("gap_first_fall", n, 10);
        wait_en(1'b1, 50, n);
        check("gap_silent_cycles", n, 2 + GAP_EXTRA);
        wait_en(1'b0, 50, n);
        for (int c = 0; c < 50 && busy; c++) tick();
        check("gap_song_ends", busy, 0);
        $display("gap: silent cycles between notes=%0d", 2 + GAP_EXTRA);

        // Looping: marker wraps to address 0 without a done pulse.
        load_song(8'h0D, 8'h01, 8'h1F);
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        en_cnt = 0; done_cnt = 0; wraps = 0; prev_addr = rom_addr;
        for (int c = 0; c < 300 && en_cnt < 40; c++) begin
            if (cnt_en) en_cnt++;
            if (done) done_cnt++;
            if (prev_addr == ADDR_W'(2) && rom_addr == '0) wraps++;
            prev_addr = rom_addr;
            tick();
        end
        check("loop_en_cycles", en_cnt, 40);
        check("loop_no_done", done_cnt, 0);
        check("loop_wrapped", (wraps > 0), 1);
        check("loop_busy", busy, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        loop_en = 1'b0;
        check("loop_stop_busy", busy, 0);
        check("loop_stop_cnt_en", cnt_en, 0);
        check("loop_stop_addr", rom_addr, 0);
        $display("loop: en=%0d wraps=%0d done=%0d", en_cnt, wraps, done_cnt);

        // stop and start together mid-PLAY: stop wins.
        load_song(8'hE8, 8'h1F, 8'h1F);
        start = 1'b1; tick(); start = 1'b0;
        wait_en(1'b1, 20, n);
        check("stop_play_reached", n, 2);
        repeat (3) tick();
        stop = 1'b1; start = 1'b1;
        tick();
        check("stop_busy", busy, 0);
        check("stop_cnt_en", cnt_en, 0);
        check("stop_addr", rom_addr, 0);
        check("stop_done", done, 0);
        tick();
        check("stop_start_busy", busy, 0);
        stop = 1'b0; start = 1'b0;
        done_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            tick();
        end
        check("stop_no_done", done_cnt, 0);
        check("stop_stays_idle", busy_cnt, 0);
        $display("stop: busy=%0d cnt_en=%0d done_pulses=%0d", busy, cnt_en, done_cnt);

        // Asynchronous reset in the middle of a note.
        start = 1'b1; tick(); start = 1'b0;
        wait_en(1'b1, 20, n);
        check("rst_play_reached", n, 2);
        #3 rst = 1'b1;
        #1;
        check("arst_cnt_en", cnt_en, 0);
        check("arst_arr", counter_arr, 0);
        check("arst_ccr", counter_ccr, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", rom_addr, 0);
        check("arst_done", done, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_no_resume_busy", busy, 0);
        check("arst_no_resume_en", cnt_en, 0);
        $display("async reset: cnt_en=%0d busy=%0d arr=%0d", cnt_en, busy, counter_arr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
